// File: rtl/rr_mux.sv
`default_nettype none
// ============================================================================
// Module  : rr_mux
// Purpose : N_CH-to-1 data mux with direct-select or round-robin arbitration,
//           feeding a single registered output slot with valid/ready handshake.
// Rev     : 1.0  initial release
// ============================================================================
module rr_mux #(
   parameter int WIDTH = 5,
   parameter int N_CH  = 32,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_ch,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [WIDTH-1:0] w_ch_data [N_CH];
   logic [SEL_W-1:0] r_ptr;
   logic [WIDTH-1:0] r_data;
   logic [SEL_W-1:0] r_ch;
   logic             r_valid;

   logic             w_space;
   logic             w_hit;
   logic             w_load;
   logic [SEL_W-1:0] w_cand;
   logic [SEL_W-1:0] w_ptr_next;

   genvar g;
   generate
      for (g = 0; g < N_CH; g++) begin : g_unpack
         assign w_ch_data[g] = in_data[g*WIDTH +: WIDTH];
      end
   endgenerate

   assign w_space = !r_valid || out_ready;

   // Candidate selection: direct index in mode 0, rotating priority from r_ptr in mode 1.
   always_comb begin
      int               v_idx;
      logic [SEL_W-1:0] v_idx_s;
      w_hit   = 1'b0;
      w_cand  = '0;
      v_idx   = 0;
      v_idx_s = '0;
      if (mode == 1'b0) begin
         if ((int'(sel) < N_CH) && in_valid[sel]) begin
            w_hit  = 1'b1;
            w_cand = sel;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            v_idx = int'(r_ptr) + i;
            if (v_idx >= N_CH) begin
               v_idx = v_idx - N_CH;
            end
            v_idx_s = v_idx[SEL_W-1:0];
            if (!w_hit && in_valid[v_idx_s]) begin
               w_hit  = 1'b1;
               w_cand = v_idx_s;
            end
         end
      end
   end

   assign w_load = rst_n && w_hit && w_space;

   always_comb begin
      in_ready = '0;
      if (w_load) begin
         in_ready[w_cand] = 1'b1;
      end
   end

   assign w_ptr_next = (int'(w_cand) == N_CH - 1) ? '0 : w_cand + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_ch    <= '0;
         r_valid <= 1'b0;
         r_ptr   <= '0;
      end else begin
         if (w_load) begin
            r_data  <= w_ch_data[w_cand];
            r_ch    <= w_cand;
            r_valid <= 1'b1;
            if (mode) begin
               r_ptr <= w_ptr_next;
            end
         end else if (out_ready) begin
            // Drain with nothing to replace it: data and channel keep last word.
            r_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_data;
   assign out_ch    = r_ch;
   assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_mux
// Purpose : Table-driven self-checking bench for rr_mux (WIDTH=5, N_CH=32).
// Rev     : 1.0  initial release
// ============================================================================
module tb_rr_mux;

   localparam int WIDTH = 5;
   localparam int N_CH  = 32;
   localparam int SEL_W = 5;

   logic                  clk;
   logic                  rst_n;
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_valid;
   logic [N_CH-1:0]       in_ready;
   logic                  mode;
   logic [SEL_W-1:0]      sel;
   logic [WIDTH-1:0]      out_data;
   logic [SEL_W-1:0]      out_ch;
   logic                  out_valid;
   logic                  out_ready;

   rr_mux #(.WIDTH(WIDTH), .N_CH(N_CH), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             mode;
      logic [SEL_W-1:0] sel;
      logic [N_CH-1:0]  valid;
      logic             oready;
      logic [N_CH-1:0]  exp_ready;
      logic             exp_valid;
      logic [WIDTH-1:0] exp_data;
      logic [SEL_W-1:0] exp_ch;
   } vec_t;

   vec_t tbl[$];
   int   n_vec;
   int   n_err;

   function automatic logic [N_CH-1:0] bit_of(input int k);
      logic [N_CH-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   function automatic void add(input logic m, input int s, input logic [N_CH-1:0] v,
                               input logic ordy, input logic [N_CH-1:0] er,
                               input logic ev, input int ed, input int ec);
      vec_t r;
      r.mode      = m;
      r.sel       = SEL_W'(s);
      r.valid     = v;
      r.oready    = ordy;
      r.exp_ready = er;
      r.exp_valid = ev;
      r.exp_data  = WIDTH'(ed);
      r.exp_ch    = SEL_W'(ec);
      tbl.push_back(r);
   endfunction

   task automatic chk(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one vector at the falling edge, check handshake, then check outputs after the rising edge.
   task automatic apply(input vec_t r, input int idx);
      mode      = r.mode;
      sel       = r.sel;
      in_valid  = r.valid;
      out_ready = r.oready;
      #1;
      chk($sformatf("row%0d in_ready", idx), in_ready, r.exp_ready);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", idx), N_CH'(out_valid), N_CH'(r.exp_valid));
      chk($sformatf("row%0d out_data", idx), N_CH'(out_data), N_CH'(r.exp_data));
      chk($sformatf("row%0d out_ch", idx), N_CH'(out_ch), N_CH'(r.exp_ch));
      @(negedge clk);
   endtask

   logic [N_CH-1:0] c_all;
   logic [N_CH-1:0] c_3_7_31;
   logic [N_CH-1:0] c_0_31;

   initial begin
      n_vec = 0;
      n_err = 0;
      c_all    = '1;
      c_3_7_31 = bit_of(3) | bit_of(7) | bit_of(31);
      c_0_31   = bit_of(0) | bit_of(31);
      for (int i = 0; i < N_CH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(i);

      // Direct-select sweep: every channel valid, sel steps 0..31.
      for (int i = 0; i < N_CH; i++) add(1'b0, i, c_all, 1'b1, bit_of(i), 1'b1, i, i);
      // Round-robin over 3, 7, 31 starting from ptr=0; ptr wraps to 0 after 31.
      add(1'b1, 0, c_3_7_31, 1'b1, bit_of(3),  1'b1, 3,  3);
      add(1'b1, 0, c_3_7_31, 1'b1, bit_of(7),  1'b1, 7,  7);
      add(1'b1, 0, c_3_7_31, 1'b1, bit_of(31), 1'b1, 31, 31);
      add(1'b1, 0, c_3_7_31, 1'b1, bit_of(3),  1'b1, 3,  3);
      add(1'b1, 0, c_3_7_31, 1'b1, bit_of(7),  1'b1, 7,  7);
      // Grant 30 to move ptr to 31, then 0/31 alternate.
      add(1'b1, 0, bit_of(30), 1'b1, bit_of(30), 1'b1, 30, 30);
      add(1'b1, 0, c_0_31, 1'b1, bit_of(31), 1'b1, 31, 31);
      add(1'b1, 0, c_0_31, 1'b1, bit_of(0),  1'b1, 0,  0);
      add(1'b1, 0, c_0_31, 1'b1, bit_of(31), 1'b1, 31, 31);
      add(1'b1, 0, c_0_31, 1'b1, bit_of(0),  1'b1, 0,  0);
      // Backpressure: hold word 7 for four cycles, then drain and load together.
      add(1'b0, 7, c_all, 1'b1, bit_of(7), 1'b1, 7, 7);
      for (int i = 0; i < 4; i++) add(1'b0, 7, c_all, 1'b0, '0, 1'b1, 7, 7);
      add(1'b0, 9, c_all, 1'b1, bit_of(9), 1'b1, 9, 9);
      // Idle drain, then a direct select of an invalid channel.
      add(1'b1, 0, '0, 1'b1, '0, 1'b0, 9, 9);
      add(1'b0, 5, bit_of(3), 1'b1, '0, 1'b0, 9, 9);

      rst_n     = 1'b0;
      mode      = 1'b0;
      sel       = '0;
      in_valid  = c_all;
      out_ready = 1'b1;
      #12;
      chk("reset in_ready", in_ready, '0);
      chk("reset out_valid", N_CH'(out_valid), '0);
      chk("reset out_data", N_CH'(out_data), '0);
      chk("reset out_ch", N_CH'(out_ch), '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // Load channel 7 in round-robin (ptr -> 8) and stall it, then reset asynchronously.
      mode      = 1'b1;
      in_valid  = bit_of(7);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("prereset out_valid", N_CH'(out_valid), N_CH'(1));
      chk("prereset out_ch", N_CH'(out_ch), N_CH'(7));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async out_valid", N_CH'(out_valid), '0);
      chk("async out_data", N_CH'(out_data), '0);
      chk("async out_ch", N_CH'(out_ch), '0);
      chk("async in_ready", in_ready, '0);
      @(negedge clk);
      rst_n     = 1'b1;
      in_valid  = bit_of(3) | bit_of(9);
      out_ready = 1'b1;
      #1;
      chk("postreset in_ready", in_ready, bit_of(3));
      @(posedge clk);
      #1;
      chk("postreset out_ch", N_CH'(out_ch), N_CH'(3));
      chk("postreset out_data", N_CH'(out_data), N_CH'(3));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter WIDTH, default 5: data bits per channel.
REQ-002 Parameter N_CH, default 32: input channel count, range 2..64.
REQ-003 Parameter SEL_W, default $clog2(N_CH): select/channel-index width.
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  N_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N_CH  per-channel data-valid.
REQ-008 in_ready  output  N_CH  per-channel accept strobe, one-hot or zero.
REQ-009 mode  input  1  0 = direct select, 1 = round-robin arbitration.
REQ-010 sel  input  SEL_W  channel index used in mode 0.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_ch  output  SEL_W  channel index of out_data.
REQ-013 out_valid  output  1  output register holds a word.
REQ-014 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-015 Output stage: single registered slot; "space" = !out_valid || out_ready.
REQ-016 Transfer out: occurs on clk edge where out_valid && out_ready.
REQ-017 Mode 0: candidate = sel; in_ready[sel] = space && in_valid[sel]; all other in_ready = 0.
REQ-018 Mode 0, sel >= N_CH: no candidate, in_ready all 0, no load.
REQ-019 Mode 1: candidate = first channel with in_valid set, searching ptr, ptr+1, ... N_CH-1, 0, ... ptr-1 (wrap).
REQ-020 Mode 1: in_ready[candidate] = space; no valid channel -> in_ready all 0.
REQ-021 Load: on edge where some in_ready[k] = 1, out_data <= channel k data, out_ch <= k, out_valid <= 1.
REQ-022 Drain without load: out_valid <= 0 and out_data, out_ch hold previous values.
REQ-023 Simultaneous drain and load in same cycle: full throughput, one word per cycle, no bubble.
REQ-024 Backpressure (out_valid && !out_ready): out_data, out_ch, out_valid hold; in_ready all 0.
REQ-025 Round-robin pointer ptr (SEL_W bits): on mode-1 load of channel k, ptr <= k+1, or 0 when k = N_CH-1.
REQ-026 ptr unchanged on mode-0 loads and on idle or stalled cycles.
REQ-027 in_ready is combinational from in_valid, mode, sel, ptr, out_valid, out_ready; latency input-accept to out_valid = 1 cycle.
REQ-028 mode or sel changes take effect the same cycle; an already-registered word is unaffected.
REQ-029 Mode-1 fairness: with M channels continuously valid, each is granted exactly once per M consecutive loads.

Reset
REQ-030 rst_n low asynchronously forces out_valid = 0, out_data = 0, out_ch = 0, ptr = 0 with no clock edge required.
REQ-031 While rst_n low: in_ready all 0.
REQ-032 Reset asserted mid-transfer discards the held word; first load after release uses ptr = 0.

Verification
REQ-033 Reset: rst_n = 0 with out_valid previously 1 -> out_valid = 0, out_data = 0, out_ch = 0 before next clk edge.
REQ-034 Mode 0 sweep: WIDTH = 5, N_CH = 32, channel i data = i, all valid, out_ready = 1, sel = 0..31 per cycle -> one cycle later out_data = out_ch = sel; every cycle valid.
REQ-035 Mode 1 grant order: valid on channels 3, 7, 31 only, out_ready = 1 -> out_ch sequence 3, 7, 31, 3, 7, ...; ptr after 31 = 0.
REQ-036 Backpressure: out_valid = 1, out_data = 7, out_ready = 0 for 4 cycles -> out_data = 7 held, in_ready = 0; out_ready = 1 -> next word loaded same edge as drain, no gap.
REQ-037 Wrap: ptr = 31, channels 0 and 31 valid -> grants 31, 0, 31, 0 alternately.
REQ-038 Idle: no in_valid, out_ready = 1 -> out_valid falls to 0 after drain; out_data holds last value.
